seq_mult: RTL and testbench

SEQ_MULT -- requirements
Module: seq_mult

---
 rtl/mult_pkg.sv | 20 ++
 rtl/seq_mult_pp.sv | 29 ++
 rtl/seq_mult.sv | 120 ++++++++++++
 tb/tb_seq_mult.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and width legality limits for seq_mult
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int A_WIDTH_MIN = 2;
  localparam int A_WIDTH_MAX = 32;
  localparam int B_WIDTH_MIN = 2;
  localparam int B_WIDTH_MAX = 16;

  function automatic bit widths_legal(input int aw, input int bw);
    return (aw >= A_WIDTH_MIN) && (aw <= A_WIDTH_MAX) &&
           (bw >= B_WIDTH_MIN) && (bw <= B_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/seq_mult_pp.sv
// rtl/seq_mult_pp.sv - combinational partial-product generator for seq_mult
module seq_mult_pp
  import mult_pkg::*;
#(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 8
) (
  input  logic                       bit_val,
  input  logic [A_WIDTH-1:0]         a,
  input  logic                       signed_mode,
  input  logic                       msb_iter,
  output logic [A_WIDTH+B_WIDTH-1:0] pp
);

  localparam int P = A_WIDTH + B_WIDTH;
  localparam logic [P-1:0] ONE = P'(1);

  logic [P-1:0] a_ext;

  // Extend a to product width; the sign bit of b carries negative weight, so its pp is negated
  always_comb begin
    a_ext = {{B_WIDTH{signed_mode & a[A_WIDTH-1]}}, a};
    pp    = '0;
    if (bit_val) begin
      pp = (signed_mode && msb_iter) ? (~a_ext + ONE) : a_ext;
    end
  end

endmodule

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - sequential shift-add multiplier, MSB-first, fixed B_WIDTH-cycle latency
module seq_mult
  import mult_pkg::*;
#(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] result
);

  localparam int P  = A_WIDTH + B_WIDTH;
  localparam int CW = $clog2(B_WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(B_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  generate
    if (!widths_legal(A_WIDTH, B_WIDTH)) begin : g_illegal_widths
      $error("seq_mult: A_WIDTH must be 2..32 and B_WIDTH must be 2..16");
    end
  endgenerate

  state_t               state;
  state_t               state_next;
  logic [A_WIDTH-1:0]   a_reg;
  logic [B_WIDTH-1:0]   b_reg;
  logic                 sm_reg;
  logic [P-1:0]         acc;
  logic [P-1:0]         acc_next;
  logic [P-1:0]         pp;
  logic [CW-1:0]        cnt;
  logic                 last_iter;

  seq_mult_pp #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_pp (
    .bit_val     (b_reg[B_WIDTH-1]),
    .a           (a_reg),
    .signed_mode (sm_reg),
    .msb_iter    (cnt == '0),
    .pp          (pp)
  );

  assign acc_next  = {acc[P-2:0], 1'b0} + pp;
  assign last_iter = (cnt == LAST_ITER);

  // State register; reset overrides any in-flight operation
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) state_next = ST_CALC;
      end
      ST_CALC: begin
        if (last_iter) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, MSB-first accumulate; result only updates when the last iteration lands
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      sm_reg <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            sm_reg <= signed_mode;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        ST_CALC: begin
          acc   <= acc_next;
          b_reg <= {b_reg[B_WIDTH-2:0], 1'b0};
          cnt   <= cnt + CNT_ONE;
          if (last_iter) result <= acc_next;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - directed self-checking bench for seq_mult
module tb_seq_mult;

  localparam int BW = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [15:0] a;
  logic [7:0]  b;
  logic        ready, busy, done;
  logic [23:0] result;

  logic        s_start;
  logic        s_signed_mode;
  logic [7:0]  s_a;
  logic [3:0]  s_b;
  logic        s_ready, s_busy, s_done;
  logic [11:0] s_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  seq_mult dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  seq_mult #(.A_WIDTH(8), .B_WIDTH(4)) dut_small (
    .clock       (clock),
    .reset       (reset),
    .start       (s_start),
    .signed_mode (s_signed_mode),
    .a           (s_a),
    .b           (s_b),
    .ready       (s_ready),
    .busy        (s_busy),
    .done        (s_done),
    .result      (s_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: present operands with start for one accept edge
  task automatic start_op(input logic sm, input logic [15:0] aa, input logic [7:0] bb);
    signed_mode = sm;
    a           = aa;
    b           = bb;
    start       = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done; optionally pulses a foreign start mid-CALC
  task automatic wait_done(input int glitch_at, output int lat, output int ndone,
                           output logic [23:0] res);
    lat   = -1;
    ndone = 0;
    res   = '0;
    for (int i = 1; i <= BW + 6; i++) begin
      if (i == glitch_at) begin
        start = 1'b1;
        a     = 16'h1234;
        b     = 8'h56;
      end
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          res = result;
        end
      end
    end
  endtask

  int          lat, ndone, t0, t1, t2, cyc, nd;
  logic [23:0] res;
  logic [23:0] bb_res [3];
  int          bb_t   [3];

  initial begin
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    s_start = 1'b0; s_signed_mode = 1'b0; s_a = '0; s_b = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_ready", {31'b0, ready}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", {8'b0, result}, 32'd0);

    // start offered in the very first cycle after reset release
    reset = 1'b0;
    start_op(1'b0, 16'hFFFF, 8'hFF);
    chk("calc_busy", {31'b0, busy}, 32'd1);
    chk("calc_ready", {31'b0, ready}, 32'd0);
    wait_done(0, lat, ndone, res);
    chk("uns_ffff_ff_result", {8'b0, res}, 32'hFEFF01);
    chk("uns_ffff_ff_latency", lat, BW);
    chk("uns_ffff_ff_ndone", ndone, 1);
    chk("hold_result", {8'b0, result}, 32'hFEFF01);
    chk("idle_ready", {31'b0, ready}, 32'd1);

    start_op(1'b1, 16'hFFFD, 8'h05);
    wait_done(0, lat, ndone, res);
    chk("sgn_m3_x5", {8'b0, res}, 32'hFFFFF1);
    chk("sgn_m3_x5_latency", lat, BW);

    start_op(1'b1, 16'h8000, 8'h80);
    wait_done(0, lat, ndone, res);
    chk("sgn_min_x_min", {8'b0, res}, 32'h400000);

    // 0x7FFF * -1 = -32767
    start_op(1'b1, 16'h7FFF, 8'hFF);
    wait_done(0, lat, ndone, res);
    chk("sgn_max_x_m1", {8'b0, res}, 32'hFF8001);

    // mid-CALC start with other operands is ignored: 100 * 3 = 300
    start_op(1'b0, 16'd100, 8'd3);
    wait_done(3, lat, ndone, res);
    chk("glitch_result", {8'b0, res}, 32'd300);
    chk("glitch_ndone", ndone, 1);
    chk("glitch_latency", lat, BW);

    // zero operand: fixed latency, zero product
    start_op(1'b0, 16'd0, 8'hAB);
    wait_done(0, lat, ndone, res);
    chk("zero_a_result", {8'b0, res}, 32'd0);
    chk("zero_a_latency", lat, BW);

    // reset during iteration 4 aborts with no done
    start_op(1'b0, 16'd9, 8'd9);
    wait_done(0, lat, ndone, res);
    chk("pre_abort_result", {8'b0, res}, 32'd81);
    start_op(1'b0, 16'd50, 8'd50);
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", {8'b0, result}, 32'd0);
    nd = 0;
    repeat (BW + 4) begin
      @(posedge clock);
      @(negedge clock);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    start_op(1'b0, 16'd1234, 8'd56);
    wait_done(0, lat, ndone, res);
    chk("post_abort_result", {8'b0, res}, 32'd69104);

    // start held high: three back-to-back unsigned operations
    signed_mode = 1'b0;
    a = 16'd3; b = 8'd7; start = 1'b1;
    cyc = 0; nd = 0;
    while (nd < 3 && cyc < 100) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (done) begin
        bb_res[nd] = result;
        bb_t[nd]   = cyc;
        nd++;
        if (nd == 1) begin a = 16'd0;    b = 8'd255; end
        if (nd == 2) begin a = 16'd1000; b = 8'd2;   end
      end
    end
    start = 1'b0;
    chk("b2b_count", nd, 3);
    if (nd == 3) begin
      chk("b2b_res0", {8'b0, bb_res[0]}, 32'd21);
      chk("b2b_res1", {8'b0, bb_res[1]}, 32'd0);
      chk("b2b_res2", {8'b0, bb_res[2]}, 32'd2000);
      t0 = bb_t[0]; t1 = bb_t[1]; t2 = bb_t[2];
      chk("b2b_space01", t1 - t0, BW + 2);
      chk("b2b_space12", t2 - t1, BW + 2);
    end
    repeat (2) @(negedge clock);

    // 8x4 instance: 127 * -8 = -1016
    s_signed_mode = 1'b1; s_a = 8'h7F; s_b = 4'h8; s_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    s_start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (s_done && lat < 0) begin
        lat = i;
        chk("small_result", {20'b0, s_result}, 32'hC08);
      end
    end
    chk("small_latency", lat, 4);
    chk("small_ready", {31'b0, s_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
